// File: rtl/mult_scheduler_pkg.sv
// Shared types and constants for the Q1.15 multiplier scheduler.
// Also provides the two's-complement magnitude helper used at request accept.
package mult_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned FRAC  = 15;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        ROUND,
        RESP
    } state_t;

    typedef logic req_id_t;

    localparam logic [WIDTH-1:0] Q_MAX = 16'h7FFF;
    localparam logic [WIDTH-1:0] Q_MIN = 16'h8000;

    // 0x8000 maps to 32768, which is representable as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] q_mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 16'd1) : x;
    endfunction

endpackage

// File: rtl/mult_scheduler_if.sv
// Request/response bundle between the effect stages and the shared multiplier.
// master = requesters plus result consumer, slave = the scheduler itself.
interface mult_scheduler_if;
    import mult_pkg::*;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;

    logic             rsp_valid;
    logic             rsp_ready;
    req_id_t          rsp_id;
    logic [WIDTH-1:0] rsp_data;

    logic             busy;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

endinterface

// File: rtl/mult_scheduler_shift_add.sv
// Iterative unsigned 16x16 shift-add multiplier: one partial product per cycle.
// start loads operands and clears the accumulator; done marks the cycle of the last step.
module shift_add_mult
    import mult_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   ma,
    input  logic [WIDTH-1:0]   mb,
    output logic               done,
    output logic [2*WIDTH-1:0] acc
);

    localparam logic [3:0] LAST_STEP = 4'(WIDTH - 1);

    logic [WIDTH-1:0] ma_r;
    logic [WIDTH-1:0] mb_r;
    logic [3:0]       step;
    logic             run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_r <= '0;
            mb_r <= '0;
            acc  <= '0;
            step <= '0;
            run  <= 1'b0;
        end else if (start) begin
            ma_r <= ma;
            mb_r <= mb;
            acc  <= '0;
            step <= '0;
            run  <= 1'b1;
        end else if (run) begin
            if (mb_r[step]) begin
                acc <= acc + ({{WIDTH{1'b0}}, ma_r} << step);
            end
            step <= step + 4'd1;
            if (step == LAST_STEP) begin
                run <= 1'b0;
            end
        end
    end

    // Combinational so the owner can leave MULT on the same edge as the final step.
    assign done = run && (step == LAST_STEP);

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin scheduler sharing one shift-add multiplier between two Q1.15 requesters.
// Handles arbitration, sign, round-half-away-from-zero, saturation and the response register.
module mult_scheduler
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    mult_scheduler_if.slave  bus
);

    state_t           state;
    logic             ptr;
    logic             sign_r;
    req_id_t          id_r;

    logic             rsp_valid_r;
    req_id_t          rsp_id_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             busy_r;

    logic             grant;
    logic             accept;
    logic [1:0]       req_ready_c;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic               core_done;
    logic [2*WIDTH-1:0] core_acc;

    logic [2*WIDTH-1:0] rnd_sum;
    logic [WIDTH:0]     mag_q;
    logic [WIDTH-1:0]   pos_q;
    logic [WIDTH-1:0]   neg_lim;
    logic [WIDTH-1:0]   q_result;

    // Arbitration: a lone requester wins outright; a tie goes to the pointer.
    always_comb begin
        grant       = (&bus.req_valid) ? ptr : bus.req_valid[1];
        accept      = rst_n && (state == IDLE) && (|bus.req_valid);
        req_ready_c = '0;
        if (accept) begin
            req_ready_c[grant] = 1'b1;
        end
        a_sel = grant ? bus.req_a1 : bus.req_a0;
        b_sel = grant ? bus.req_b1 : bus.req_b0;
        a_mag = q_mag(a_sel);
        b_mag = q_mag(b_sel);
    end

    shift_add_mult u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .ma    (a_mag),
        .mb    (b_mag),
        .done  (core_done),
        .acc   (core_acc)
    );

    // Rounding acts on the magnitude, so it is half away from zero once the sign is applied.
    always_comb begin
        rnd_sum  = core_acc + (32'd1 << (FRAC - 1));
        mag_q    = rnd_sum[FRAC +: WIDTH + 1];
        pos_q    = (mag_q > {1'b0, Q_MAX}) ? Q_MAX : mag_q[WIDTH-1:0];
        neg_lim  = (mag_q >= {1'b0, Q_MIN}) ? Q_MIN : mag_q[WIDTH-1:0];
        q_result = sign_r ? (~neg_lim + 16'd1) : pos_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            sign_r      <= 1'b0;
            id_r        <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_data_r  <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_r <= a_sel[WIDTH-1] ^ b_sel[WIDTH-1];
                        id_r   <= grant;
                        ptr    <= ~grant;
                        state  <= MULT;
                        busy_r <= 1'b1;
                    end
                end
                MULT: begin
                    if (core_done) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    rsp_data_r  <= q_result;
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state       <= IDLE;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mult_scheduler.sv
// Scoreboard bench for mult_scheduler: expectations queued at drive time, checked at response handshake.
module tb_mult_scheduler;
    import mult_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_scheduler_if bus ();

    mult_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        id;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_acc_edge = 0;
    int last_hs_edge = 0;
    int acc_count = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: full signed product, round magnitude half away from zero, saturate.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        int p;
        int mag;
        int m;
        p   = int'($signed(a)) * int'($signed(b));
        mag = (p < 0) ? -p : p;
        m   = (mag + 16384) >> 15;
        if (p >= 0) begin
            if (m > 32767) m = 32767;
        end else begin
            if (m > 32768) m = 32768;
            m = -m;
        end
        return m[15:0];
    endfunction

    // Passive monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (|(bus.req_valid & bus.req_ready)) begin
                check_eq("ready_onehot", $countones(bus.req_ready), 1);
                if (last_hs_edge > 0) begin
                    check_eq("accept_gap", 32'(cyc + 1 > last_hs_edge), 1);
                    last_hs_edge = 0;
                end
                last_acc_edge = cyc + 1;
                acc_count++;
            end
            if (bus.rsp_valid && !prev_valid) begin
                check_eq("latency", cyc - last_acc_edge, 17);
            end
            prev_valid = bus.rsp_valid;
            if (bus.rsp_valid && bus.rsp_ready) begin
                last_hs_edge = cyc + 1;
                if (sb.size() == 0) begin
                    check_eq("spurious_rsp", bus.rsp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("rsp_id", bus.rsp_id, e.id);
                    check_eq("rsp_data", bus.rsp_data, e.data);
                end
            end
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic issue(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp, input bit want_rsp);
        bit ok;
        if (id) begin
            bus.req_a1 = a;
            bus.req_b1 = b;
        end else begin
            bus.req_a0 = a;
            bus.req_b0 = b;
        end
        if (want_rsp) sb.push_back('{id: id, data: exp});
        bus.req_valid[id] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready[id]) ok = 1'b1;
        end
        if (!ok) check_eq("accept_timeout", bus.req_ready[id], 1);
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        check_eq("drain", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, bus.req_ready, 0);
        check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check_eq({tag, "_rsp_id"}, bus.rsp_id, 0);
        check_eq({tag, "_rsp_data"}, bus.rsp_data, 0);
        check_eq({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cap_data;
        logic        cap_id;
        logic        rid;
        logic [15:0] ra;
        logic [15:0] rb;
        int          base;
        bit          seen;

        bus.req_valid = '0;
        bus.req_a0 = '0;
        bus.req_b0 = '0;
        bus.req_a1 = '0;
        bus.req_b1 = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic cases with hand-derived results.
        issue(1'b0, 16'h4000, 16'h4000, 16'h2000, 1'b1); drain();
        issue(1'b1, 16'h8000, 16'h8000, 16'h7FFF, 1'b1); drain();
        issue(1'b1, 16'h8000, 16'h4000, 16'hC000, 1'b1); drain();
        issue(1'b1, 16'h0001, 16'h4000, 16'h0001, 1'b1); drain();
        issue(1'b0, 16'h0000, 16'h8000, 16'h0000, 1'b1); drain();
        issue(1'b0, 16'h8000, 16'h7FFF, 16'h8001, 1'b1); drain();
        issue(1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFE, 1'b1); drain();

        // Stalled response: outputs frozen, requesters blocked.
        bus.rsp_ready = 1'b0;
        issue(1'b1, 16'h2000, 16'h2000, 16'h0800, 1'b1);
        bus.req_a0 = 16'h4000;
        bus.req_b0 = 16'hC000;
        sb.push_back('{id: 1'b0, data: 16'hE000});
        bus.req_valid[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check_eq("stall_rsp_seen", bus.rsp_valid, 1);
        cap_data = bus.rsp_data;
        cap_id = bus.rsp_id;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("stall_data", bus.rsp_data, cap_data);
            check_eq("stall_id", bus.rsp_id, cap_id);
            check_eq("stall_valid", bus.rsp_valid, 1);
            check_eq("stall_req_ready", bus.req_ready, 0);
            check_eq("stall_busy", bus.busy, 1);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.req_ready[0]) seen = 1'b1;
        end
        check_eq("post_stall_accept", bus.req_ready[0], 1);
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        drain();

        // Reset mid-multiply: abandoned, no response.
        issue(1'b0, 16'h4000, 16'h4000, 16'h0000, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_eq("abort_no_rsp", bus.rsp_valid, 0);
        check_eq("abort_busy", bus.busy, 0);

        // Both requesters valid: pointer restarts at 0, grants alternate.
        bus.req_a0 = 16'h6000;
        bus.req_b0 = 16'h3000;
        bus.req_a1 = 16'hA000;
        bus.req_b1 = 16'h5000;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sb.push_back('{id: 1'b0, data: model(16'h6000, 16'h3000)});
            else            sb.push_back('{id: 1'b1, data: model(16'hA000, 16'h5000)});
        end
        base = acc_count;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 400 && acc_count < base + 4; i++) @(negedge clk);
        check_eq("grant_count", acc_count - base, 4);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        drain();

        // Random operands, including the full-scale corners.
        for (int i = 0; i < 16; i++) begin
            rid = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 5 == 0) ra = 16'h8000;
            if (i % 7 == 0) rb = 16'h7FFF;
            issue(rid, ra, rb, model(ra, rb), 1'b1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
